init_write_buffer: RTL and testbench
====================================

# init_write_buffer

Buffered, flow-controlled successor to the boot-time initial-data write path. It accepts (address, data) init words from the loader side and queues them in a DEPTH-entry FIFO. It issues them as memory write requests with a valid/ready handshake and tracks in-flight writes until their responses return. `empty` rises only when every accepted word has been written and acknowledged, and the core uses it as the init-end signal.

## Interface
- DATA_W, 32, init data width
- ADDR_W, 32, init address width
- DEPTH, 16, FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 4, maximum issued-but-unacknowledged writes; ≥1
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- init_data_valid  in  1  loader presents a word this cycle
- init_data_addr  in  ADDR_W  write address
- init_data  in  DATA_W  write data
- init_data_ready  out  1  FIFO not full; loader may honour it, but dropping is defined
- req_valid  out  1  write request valid
- init_write_addr  out  ADDR_W  request address (FIFO head)
- init_write_data  out  DATA_W  request data (FIFO head)
- req_ready  in  1  memory accepts request
- rsp_valid  in  1  one write acknowledged this cycle
- empty  out  1  init end: FIFO empty and zero outstanding
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- rsp_error  out  1  sticky: rsp_valid arrived with zero outstanding
- write_count  out  32  acknowledged writes since reset, wraps at 2^32

## Operation
- FIFO uses read and write pointers of log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. It is first-word-fall-through: head address and data drive `init_write_addr` and `init_write_data` directly.
- Push: `init_data_valid && !full`, where full is the state at the start of the cycle. If `init_data_valid && full`, the word is dropped and `overflow` is set. A pop in the same cycle does not rescue a push into a full FIFO.
- Issue: `req_valid = !fifo_empty && (outstanding < MAX_OUTSTANDING)`. A pop occurs on `req_valid && req_ready`. Head address and data stay stable while `req_valid && !req_ready`.
- Simultaneous push and pop, with the FIFO neither full nor empty: both happen and the count is unchanged.
- Outstanding counter, width log2(MAX_OUTSTANDING+1):
  - +1 on issue.
  - −1 on `rsp_valid`.
  - Issue and response in the same cycle leave it unchanged.
  - `rsp_valid` with outstanding==0 and no issue that cycle is ignored: the counter stays 0 and `rsp_error` is set.
- `write_count` increments on every counted (non-error) `rsp_valid`.
- `empty = fifo_empty && outstanding==0`, combinational from registered state. It ignores the current-cycle `init_data_valid`.
- `overflow` and `rsp_error` clear only on reset.

## Timing
- Reset values:
  - Pointers 0, outstanding 0, `write_count` 0.
  - `overflow` 0, `rsp_error` 0.
  - `req_valid` 0, `empty` 1, `init_data_ready` 1.
- Reset mid-operation discards queued and in-flight bookkeeping in one cycle. Responses arriving after reset count as `rsp_error`.
- Push-to-request latency is 1 cycle: a word pushed at edge N gives `req_valid` high in cycle N+1 when outstanding permits.
- Throughput is 1 request per cycle while `req_ready`=1 and outstanding < MAX_OUTSTANDING.
- `init_data_ready` reflects registered state and deasserts the cycle after the push that fills the FIFO.
- `empty` falls the cycle after the first push and rises the cycle after the last acknowledge.

## Test plan
- Reset, then idle for 5 cycles -> `empty`=1, `req_valid`=0, `init_data_ready`=1, `write_count`=0.
- Push one word (addr 0x100, data 0xDEADBEEF) with `req_ready`=1, then pulse `rsp_valid` 3 cycles later -> `req_valid` for exactly 1 cycle carrying those values; `empty` returns to 1 after the ack; `write_count`=1.
- Burst 8 words with `req_ready`=1 and no `rsp_valid` -> exactly MAX_OUTSTANDING=4 issued, `req_valid` held 0; issuing resumes one word per `rsp_valid` pulse; after 8 acks, `write_count`=8 and `empty`=1.
- Hold `req_ready`=0 and push 17 words (DEPTH=16) -> `init_data_ready` low after the 16th, the 17th dropped, `overflow`=1; on release, 16 requests issue in order with the original addresses.
- `req_ready` toggling every cycle during a 10-word stream -> head stable while stalled, no duplicates or losses, and addresses in push order.
- `rsp_valid` with nothing outstanding, and separately reset asserted with 3 writes in flight -> `rsp_error`=1 with `write_count` unchanged; after the reset, all outputs return to their reset values.

Source files
------------

// File: rtl/init_write_buffer.sv
// Queues boot-time (address, data) init words and issues them as flow-controlled memory writes.
// FWFT head feeds the request bus; empty asserts once every accepted word has been acknowledged.
module init_write_buffer #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_data_valid,
  input  logic [ADDR_W-1:0] init_data_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_data_ready,
  output logic              req_valid,
  output logic [ADDR_W-1:0] init_write_addr,
  output logic [DATA_W-1:0] init_write_data,
  input  logic              req_ready,
  input  logic              rsp_valid,
  output logic              empty,
  output logic              overflow,
  output logic              rsp_error,
  output logic [31:0]       write_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     outstanding;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic rsp_counted;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full is judged on start-of-cycle state, so a same-cycle pop never rescues a push.
  assign push        = init_data_valid && !fifo_full;
  assign req_valid   = !fifo_empty && (outstanding < MAX_OUT);
  assign pop         = req_valid && req_ready;
  // A response is legitimate if something is in flight or is being issued this very cycle.
  assign rsp_counted = rsp_valid && (pop || (outstanding != '0));

  assign init_data_ready = !fifo_full;
  assign empty           = fifo_empty && (outstanding == '0);
  assign init_write_addr = addr_mem[rd_ptr[AW-1:0]];
  assign init_write_data = data_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[AW-1:0]] <= init_data_addr;
      data_mem[wr_ptr[AW-1:0]] <= init_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      overflow    <= 1'b0;
      rsp_error   <= 1'b0;
      write_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (init_data_valid && fifo_full) overflow <= 1'b1;

      if (pop && !rsp_counted)
        outstanding <= outstanding + OW'(1);
      else if (!pop && rsp_counted)
        outstanding <= outstanding - OW'(1);

      if (rsp_valid && !rsp_counted) rsp_error <= 1'b1;
      if (rsp_counted) write_count <= write_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_init_write_buffer.sv
// Randomised bench for init_write_buffer against a queue-based transaction model.
module tb_init_write_buffer;

  localparam int DEP  = 16;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_data_valid = 1'b0;
  logic [31:0] init_data_addr = '0;
  logic [31:0] init_data = '0;
  logic        init_data_ready;
  logic        req_valid;
  logic [31:0] init_write_addr;
  logic [31:0] init_write_data;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic        empty;
  logic        overflow;
  logic        rsp_error;
  logic [31:0] write_count;

  init_write_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .init_data_valid(init_data_valid), .init_data_addr(init_data_addr), .init_data(init_data),
    .init_data_ready(init_data_ready),
    .req_valid(req_valid), .init_write_addr(init_write_addr), .init_write_data(init_write_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .empty(empty), .overflow(overflow), .rsp_error(rsp_error), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queue of pending words plus in-flight count and flags.
  logic [63:0] mq[$];
  int          m_out = 0;
  logic [31:0] m_wc = '0;
  logic        m_ovf = 1'b0;
  logic        m_err = 1'b0;

  // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic rr, input logic rv, input logic rst);
    bit iss, was_full;
    init_data_valid = v; init_data_addr = a; init_data = d;
    req_ready = rr; rsp_valid = rv; reset = rst;
    iss      = (mq.size() != 0) && (m_out < MAXO) && rr;
    was_full = (mq.size() == DEP);
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_out = 0; m_wc = '0; m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      if (iss) void'(mq.pop_front());
      if (v) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back({a, d});
      end
      if (iss && rv) m_wc++;
      else if (iss) m_out++;
      else if (rv) begin
        if (m_out == 0) m_err = 1'b1;
        else begin m_out--; m_wc++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    repeat (5) tick(0, 0, 0, 0, 0, 0);
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    n_chk++; if (init_data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", init_data_ready); end
    n_chk++; if (write_count !== 32'd0) begin n_fail++; $display("FAIL reset_write_count: got %0d want 0", write_count); end
    n_chk++; if (overflow !== 1'b0 || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ovf=%b err=%b want 0 0", overflow, rsp_error); end
  endtask

  task automatic test_single();
    int hi = 0;
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 32'h100, 32'hDEADBEEF, 1, 0, 0);
    n_chk++; if (req_valid !== 1'b1 || init_write_addr !== 32'h100 || init_write_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_req: got v=%b a=%h d=%h want 1 100 deadbeef", req_valid, init_write_addr, init_write_data); end
    n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_fall: got %b want 0", empty); end
    for (int i = 0; i < 5; i++) begin
      if (req_valid) hi++;
      tick(0, 0, 0, 1, (i == 3), 0);
    end
    n_chk++; if (hi != 1) begin n_fail++; $display("FAIL single_req_cycles: got %0d want 1", hi); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_rise: got %b want 1", empty); end
    n_chk++; if (write_count !== 32'd1) begin n_fail++; $display("FAIL single_write_count: got %0d want 1", write_count); end
  endtask

  task automatic test_burst_outstanding();
    int iss = 0;
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (req_valid) iss++;
      tick(1, 32'h200 + 32'(i * 4), $urandom, 1, 0, 0);
    end
    repeat (3) begin
      if (req_valid) iss++;
      tick(0, 0, 0, 1, 0, 0);
    end
    n_chk++; if (iss != MAXO) begin n_fail++; $display("FAIL burst_issued_cap: got %0d want %0d", iss, MAXO); end
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL burst_req_held: got %b want 0", req_valid); end
    for (int k = 0; k < 8; k++) begin
      if (req_valid) iss++;
      tick(0, 0, 0, 1, 1, 0);
      n_chk++; if (req_valid !== (k < 4)) begin
        n_fail++; $display("FAIL burst_resume_%0d: got %b want %b", k, req_valid, (k < 4)); end
      if (req_valid) iss++;
      tick(0, 0, 0, 1, 0, 0);
    end
    n_chk++; if (iss != 8) begin n_fail++; $display("FAIL burst_total_issued: got %0d want 8", iss); end
    n_chk++; if (write_count !== 32'd8 || empty !== 1'b1) begin
      n_fail++; $display("FAIL burst_done: got wc=%0d empty=%b want 8 1", write_count, empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] a[17];
    int got = 0, cyc = 0;
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      a[i] = $urandom;
      if (i == 15) begin
        n_chk++; if (init_data_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_before_full: got %b want 1", init_data_ready); end
      end
      if (i == 16) begin
        n_chk++; if (init_data_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", init_data_ready); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      tick(1, a[i], ~a[i], 0, 0, 0);
    end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    while (got < 16 && cyc < 200) begin
      if (req_valid) begin
        n_chk++; if (init_write_addr !== a[got] || init_write_data !== ~a[got]) begin
          n_fail++; $display("FAIL ovf_order_%0d: got %h/%h want %h/%h", got, init_write_addr, init_write_data, a[got], ~a[got]); end
        got++;
      end
      tick(0, 0, 0, 1, (m_out > 0), 0);
      cyc++;
    end
    n_chk++; if (got != 16) begin n_fail++; $display("FAIL ovf_drain_timeout: got %0d issued want 16", got); end
    while (m_out > 0 && cyc < 300) begin tick(0, 0, 0, 1, 1, 0); cyc++; end
    n_chk++; if (write_count !== 32'd16 || empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_final: got wc=%0d empty=%b ovf=%b want 16 1 1", write_count, empty, overflow); end
  endtask

  task automatic test_back_to_back_toggle();
    logic [31:0] a[10];
    int pi = 0, got = 0, cyc = 0;
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) a[i] = 32'h4000 + 32'($urandom_range(0, 255)) * 16 + 32'(i);
    while (got < 10 && cyc < 200) begin
      logic rr;
      rr = cyc[0];
      n_chk++; if (req_valid !== ((mq.size() != 0) && (m_out < MAXO))) begin
        n_fail++; $display("FAIL toggle_req_valid_c%0d: got %b want %b", cyc, req_valid, ((mq.size() != 0) && (m_out < MAXO))); end
      if (req_valid) begin
        n_chk++; if (init_write_addr !== a[got]) begin
          n_fail++; $display("FAIL toggle_head_c%0d: got %h want %h", cyc, init_write_addr, a[got]); end
        if (rr) got++;
      end
      tick(pi < 10, (pi < 10) ? a[pi] : 32'd0, 32'(pi), rr, (m_out > 0) && ($urandom_range(0, 1) == 1), 0);
      if (pi < 10) pi++;
      cyc++;
    end
    n_chk++; if (got != 10) begin n_fail++; $display("FAIL toggle_timeout: got %0d want 10", got); end
    while (m_out > 0 && cyc < 300) begin tick(0, 0, 0, 1, 1, 0); cyc++; end
    n_chk++; if (write_count !== 32'd10 || empty !== 1'b1) begin
      n_fail++; $display("FAIL toggle_final: got wc=%0d empty=%b want 10 1", write_count, empty); end
  endtask

  task automatic test_rsp_error_and_reset();
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 1, 0);
    n_chk++; if (rsp_error !== 1'b1 || write_count !== 32'd0) begin
      n_fail++; $display("FAIL err_idle: got err=%b wc=%0d want 1 0", rsp_error, write_count); end
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 32'h300 + 32'(i), 32'(i), 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    n_chk++; if (req_valid !== 1'b0 || empty !== 1'b0) begin
      n_fail++; $display("FAIL err_inflight: got v=%b empty=%b want 0 0", req_valid, empty); end
    tick(0, 0, 0, 1, 0, 1);
    n_chk++; if (empty !== 1'b1 || req_valid !== 1'b0 || init_data_ready !== 1'b1 || write_count !== 32'd0
                 || overflow !== 1'b0 || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL err_reset_vals: got e=%b v=%b r=%b wc=%0d o=%b x=%b want 1 0 1 0 0 0",
                         empty, req_valid, init_data_ready, write_count, overflow, rsp_error); end
    repeat (3) tick(0, 0, 0, 1, 1, 0);
    n_chk++; if (rsp_error !== 1'b1 || write_count !== 32'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL err_late_rsp: got err=%b wc=%0d empty=%b want 1 0 1", rsp_error, write_count, empty); end
  endtask

  task automatic test_random();
    tick(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ra;
      logic        ev, er, ee;
      ev = (mq.size() != 0) && (m_out < MAXO);
      er = (mq.size() < DEP);
      ee = (mq.size() == 0) && (m_out == 0);
      n_chk++; if (req_valid !== ev || init_data_ready !== er || empty !== ee) begin
        n_fail++; $display("FAIL rand_ctrl_c%0d: got v=%b r=%b e=%b want %b %b %b", c, req_valid, init_data_ready, empty, ev, er, ee); end
      n_chk++; if (write_count !== m_wc || overflow !== m_ovf || rsp_error !== m_err) begin
        n_fail++; $display("FAIL rand_stat_c%0d: got wc=%0d o=%b x=%b want %0d %b %b", c, write_count, overflow, rsp_error, m_wc, m_ovf, m_err); end
      if (ev) begin
        n_chk++; if ({init_write_addr, init_write_data} !== mq[0]) begin
          n_fail++; $display("FAIL rand_head_c%0d: got %h want %h", c, {init_write_addr, init_write_data}, mq[0]); end
      end
      ra = $urandom;
      tick($urandom_range(0, 2) != 0, ra, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, (c == 300));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_burst_outstanding();
    test_overflow();
    test_back_to_back_toggle();
    test_rsp_error_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
